// File: rtl/serdes_align_ctrl_if.sv
// serdes_align_ctrl_if: parallel-side link between the alignment controller
// and the OSERDES/ISERDES loopback pair.
//   master : controller (drives reset, output enable, transmit word, bitslip)
//   slave  : SERDES pair (returns the deserialized word)
interface serdes_align_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  serdes_rst;
    logic                  tx_en;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  bitslip;

    modport master (
        output serdes_rst,
        output tx_en,
        output tx_word,
        output bitslip,
        input  rx_word
    );

    modport slave (
        input  serdes_rst,
        input  tx_en,
        input  tx_word,
        input  bitslip,
        output rx_word
    );
endinterface

// File: rtl/serdes_align_ctrl.sv
// serdes_align_ctrl: bring-up controller for the SERDES loopback path.
// Waits for PLL lock, holds the SERDES pair in reset, trains word alignment
// with bitslip pulses, then checks an incrementing counter for bit errors.
// Optional feature macro: SERDES_ALIGN_ERRCNT_EN builds the saturating
// error counter; without it err_cnt is tied to zero and only the sticky
// err flag reports check errors.
module serdes_align_ctrl #(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] TRAIN_PATTERN = 8'hF0,
    parameter int         RST_CYCLES    = 16,
    parameter int         SETTLE        = 4,
    parameter int         MATCH_COUNT   = 8,
    parameter int         CHECK_SKIP    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    serdes_align_ctrl_if.master  link,
    output logic                 aligned,
    output logic                 fail,
    output logic                 err,
    output logic [15:0]          err_cnt,
    output logic [3:0]           slip_cnt
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_RESET     = 3'd1,
        ST_TRAIN     = 3'd2,
        ST_CHECK     = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0] TRAIN_WORD  = TRAIN_PATTERN[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] ONE_W       = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W      = DATA_WIDTH'(0);
    localparam logic [15:0]           RST_LOAD    = 16'(RST_CYCLES - 1);
    localparam logic [7:0]            SETTLE_LOAD = 8'(SETTLE);
    localparam logic [7:0]            MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [7:0]            SKIP_LOAD   = 8'(CHECK_SKIP);
    localparam logic [3:0]            SLIP_MAX    = 4'(DATA_WIDTH);

    state_t                state_r, state_s;
    logic [15:0]           rst_cnt_r, rst_cnt_s;
    logic [7:0]            wait_cnt_r, wait_cnt_s;
    logic [7:0]            match_cnt_r, match_cnt_s;
    logic [7:0]            skip_cnt_r, skip_cnt_s;
    logic [DATA_WIDTH-1:0] prev_rx_r, prev_rx_s;
    logic [DATA_WIDTH-1:0] tx_word_r, tx_word_s;
    logic                  serdes_rst_r, serdes_rst_s;
    logic                  tx_en_r, tx_en_s;
    logic                  bitslip_r, bitslip_s;
    logic                  aligned_r, aligned_s;
    logic                  fail_r, fail_s;
    logic                  err_r;
    logic [3:0]            slip_cnt_r, slip_cnt_s;
    logic                  err_hit_s;
    logic                  clr_err_s;
    logic                  lock_lost_s;

    // State register; synchronous reset returns to WAIT_LOCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_WAIT_LOCK;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state so
    // they change on the same edge as the state register.
    always_comb begin
        state_s      = state_r;
        rst_cnt_s    = rst_cnt_r;
        wait_cnt_s   = wait_cnt_r;
        match_cnt_s  = match_cnt_r;
        skip_cnt_s   = skip_cnt_r;
        prev_rx_s    = prev_rx_r;
        slip_cnt_s   = slip_cnt_r;
        bitslip_s    = 1'b0;
        err_hit_s    = 1'b0;
        clr_err_s    = 1'b0;
        tx_word_s    = ZERO_W;
        serdes_rst_s = 1'b1;
        tx_en_s      = 1'b0;
        aligned_s    = 1'b0;
        fail_s       = 1'b0;
        lock_lost_s  = (state_r != ST_WAIT_LOCK) && !pll_locked;

        if (lock_lost_s) begin
            // Losing lock aborts everything; err, err_cnt and slip_cnt are
            // kept for inspection until the next RESET entry.
            state_s     = ST_WAIT_LOCK;
            match_cnt_s = 8'd0;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (pll_locked) begin
                        state_s    = ST_RESET;
                        rst_cnt_s  = RST_LOAD;
                        clr_err_s  = 1'b1;
                        slip_cnt_s = 4'd0;
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_r == 16'd0) begin
                        state_s     = ST_TRAIN;
                        wait_cnt_s  = SETTLE_LOAD;
                        match_cnt_s = 8'd0;
                    end else begin
                        rst_cnt_s = rst_cnt_r - 16'd1;
                    end
                end
                ST_TRAIN: begin
                    if (wait_cnt_r != 8'd0) begin
                        wait_cnt_s = wait_cnt_r - 8'd1;
                    end else if (link.rx_word == TRAIN_WORD) begin
                        if (match_cnt_r == MATCH_LAST) begin
                            state_s     = ST_CHECK;
                            skip_cnt_s  = SKIP_LOAD;
                            match_cnt_s = 8'd0;
                        end else begin
                            match_cnt_s = match_cnt_r + 8'd1;
                        end
                    end else begin
                        match_cnt_s = 8'd0;
                        // Every rotation tried: give up without a final pulse.
                        if (slip_cnt_r == SLIP_MAX) begin
                            state_s = ST_FAIL;
                        end else begin
                            bitslip_s  = 1'b1;
                            slip_cnt_s = slip_cnt_r + 4'd1;
                            wait_cnt_s = SETTLE_LOAD;
                        end
                    end
                end
                ST_CHECK: begin
                    prev_rx_s = link.rx_word;
                    if (skip_cnt_r != 8'd0) begin
                        skip_cnt_s = skip_cnt_r - 8'd1;
                    end else if (link.rx_word != (prev_rx_r + ONE_W)) begin
                        err_hit_s = 1'b1;
                    end else begin
                        err_hit_s = 1'b0;
                    end
                end
                ST_FAIL: begin
                    state_s = ST_FAIL;
                end
                default: begin
                    state_s = ST_WAIT_LOCK;
                end
            endcase
        end

        case (state_s)
            ST_WAIT_LOCK: begin
                serdes_rst_s = 1'b1;
                tx_en_s      = 1'b0;
            end
            ST_RESET: begin
                serdes_rst_s = 1'b1;
                tx_en_s      = 1'b0;
            end
            ST_TRAIN: begin
                serdes_rst_s = 1'b0;
                tx_en_s      = 1'b1;
                tx_word_s    = TRAIN_WORD;
            end
            ST_CHECK: begin
                serdes_rst_s = 1'b0;
                tx_en_s      = 1'b1;
                aligned_s    = 1'b1;
                // Counter pattern restarts from zero on CHECK entry.
                if (state_r == ST_CHECK) begin
                    tx_word_s = tx_word_r + ONE_W;
                end else begin
                    tx_word_s = ZERO_W;
                end
            end
            ST_FAIL: begin
                serdes_rst_s = 1'b0;
                tx_en_s      = 1'b0;
                fail_s       = 1'b1;
            end
            default: begin
                serdes_rst_s = 1'b1;
                tx_en_s      = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt_r    <= 16'd0;
            wait_cnt_r   <= 8'd0;
            match_cnt_r  <= 8'd0;
            skip_cnt_r   <= 8'd0;
            prev_rx_r    <= ZERO_W;
            tx_word_r    <= ZERO_W;
            serdes_rst_r <= 1'b1;
            tx_en_r      <= 1'b0;
            bitslip_r    <= 1'b0;
            aligned_r    <= 1'b0;
            fail_r       <= 1'b0;
            slip_cnt_r   <= 4'd0;
        end else begin
            rst_cnt_r    <= rst_cnt_s;
            wait_cnt_r   <= wait_cnt_s;
            match_cnt_r  <= match_cnt_s;
            skip_cnt_r   <= skip_cnt_s;
            prev_rx_r    <= prev_rx_s;
            tx_word_r    <= tx_word_s;
            serdes_rst_r <= serdes_rst_s;
            tx_en_r      <= tx_en_s;
            bitslip_r    <= bitslip_s;
            aligned_r    <= aligned_s;
            fail_r       <= fail_s;
            slip_cnt_r   <= slip_cnt_s;
        end
    end

    // Sticky check-error flag, cleared on RESET entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (clr_err_s) begin
            err_r <= 1'b0;
        end else if (err_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

`ifdef SERDES_ALIGN_ERRCNT_EN
    logic [15:0] err_cnt_r;

    // Saturating check-error counter, cleared on RESET entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 16'h0000;
        end else if (clr_err_s) begin
            err_cnt_r <= 16'h0000;
        end else if (err_hit_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 16'h0000;
`endif

    assign link.serdes_rst = serdes_rst_r;
    assign link.tx_en      = tx_en_r;
    assign link.tx_word    = tx_word_r;
    assign link.bitslip    = bitslip_r;
    assign aligned         = aligned_r;
    assign fail            = fail_r;
    assign err             = err_r;
    assign slip_cnt        = slip_cnt_r;

endmodule

// File: doc/serdes_align_ctrl.md
# serdes_align_ctrl

Link bring-up controller for the OSERDES/ISERDES loopback path behind the bidirectional test pad. It waits for PLL lock, holds the SERDES pair in reset, and drives a training word. It then pulses bitslip until the deserialized word matches, and switches to an incrementing-counter check that flags bit errors. It runs in the CLKDIV domain and supplies the SERDES reset, transmit word, tristate enable and bitslip; the LEDs show its status.

## Interface
- DATA_WIDTH, 8, SERDES word width; legal values 2..8.
- TRAIN_PATTERN, 8'hF0, training word, masked to DATA_WIDTH bits; all DATA_WIDTH rotations must be distinct.
- RST_CYCLES, 16, SERDES reset hold length in clk cycles (≥2).
- SETTLE, 4, cycles ignored after entering TRAIN and after each bitslip (≥1).
- MATCH_COUNT, 8, consecutive matching words required to declare alignment (1..255).
- CHECK_SKIP, 8, cycles ignored after entering CHECK.
- clk, in, 1, CLKDIV-domain clock.
- rst, in, 1, reset: synchronous, active-high.
- pll_locked, in, 1, PLL LOCKED, already synchronized to clk.
- serdes_rst, out, 1, reset to the OSERDES and ISERDES.
- tx_en, out, 1, pad output enable; the tristate input is ~tx_en.
- tx_word, out, DATA_WIDTH, parallel word to the OSERDES.
- rx_word, in, DATA_WIDTH, parallel word from the ISERDES.
- bitslip, out, 1, single-cycle bitslip pulse to the ISERDES.
- aligned, out, 1, high in CHECK.
- fail, out, 1, alignment failed (terminal).
- err, out, 1, sticky check error.
- err_cnt, out, 16, saturating check-error count.
- slip_cnt, out, 4, bitslips issued in the current training.

## Operation
- States: WAIT_LOCK, RESET, TRAIN, CHECK, FAIL.
- WAIT_LOCK: serdes_rst=1, tx_en=0. Goes to RESET when pll_locked=1.
- RESET: serdes_rst=1 for RST_CYCLES cycles. On entry, clears err, err_cnt and slip_cnt. Then goes to TRAIN.
- TRAIN: serdes_rst=0, tx_en=1, tx_word=TRAIN_PATTERN.
  - A wait counter is loaded with SETTLE on entry and after each bitslip. No comparison happens while it is non-zero.
  - Match (rx_word == masked TRAIN_PATTERN): match_cnt++. When match_cnt reaches MATCH_COUNT, go to CHECK.
  - Mismatch: match_cnt=0.
    - If slip_cnt == DATA_WIDTH, go to FAIL.
    - Otherwise, pulse bitslip for one cycle, increment slip_cnt and reload the wait counter.
- CHECK: aligned=1, tx_en=1. tx_word starts at 0 and increments mod 2^DATA_WIDTH every cycle.
  - The first CHECK_SKIP cycles only record prev_rx.
  - After that, each cycle with rx_word != prev_rx+1 (mod 2^DATA_WIDTH) is an error. On error: err=1 and err_cnt increments (see Configuration).
  - prev_rx <= rx_word every cycle.
  - Stays in CHECK until pll_locked drops or rst.
- FAIL: fail=1, tx_en=0, serdes_rst=0. Left only on rst or loss of lock.
- pll_locked=0 in any state other than WAIT_LOCK: go to WAIT_LOCK next cycle.
  - aligned, fail, bitslip and match_cnt are cleared.
  - err, err_cnt and slip_cnt hold until the next RESET entry.
- err_cnt saturates at 16'hFFFF.
- All comparisons use only bits [DATA_WIDTH-1:0]. Unused upper bits of outputs are driven to 0.

## Timing
- All outputs are registered and change on the clk edge after the state change.
- Reset values: serdes_rst=1, tx_en=0, tx_word=0, bitslip=0, aligned=0, fail=0, err=0, err_cnt=0, slip_cnt=0, state=WAIT_LOCK.
- pll_locked rising in WAIT_LOCK: serdes_rst stays high for exactly RST_CYCLES cycles after the RESET entry edge.
- Bitslip spacing: two pulses are at least SETTLE+1 cycles apart. A pulse is never issued in the same cycle as a state change.
- Alignment latency: from the last slip, at least SETTLE+MATCH_COUNT cycles to aligned=1.
- If rst and pll_locked fall in the same cycle, rst wins.
- If a mismatch and the FAIL condition occur in the same cycle, FAIL is entered and no bitslip is pulsed.

## Configuration
- SERDES_ALIGN_ERRCNT_EN defined: err_cnt counts CHECK errors, saturating as specified.
- Not defined: the counter is not built, err_cnt is tied to 0, and only the sticky err flag reports errors.

## Test plan
- Ideal loopback model with 0 bit offset: lock at cycle 10 -> serdes_rst low 16 cycles after RESET entry, slip_cnt=0, aligned=1 after 4+8 cycles in TRAIN, err=0 over 1000 CHECK cycles.
- Model with 3-bit rotation, DATA_WIDTH=8: exactly 3 bitslip pulses, each ≥5 cycles apart; slip_cnt=3; aligned=1.
- Model that never matches: 8 bitslips, then fail=1 and tx_en=0; bitslip remains 0 afterwards.
- Inject a single flipped bit in CHECK: err=1 and err_cnt=2 (corrupt word plus the following word); aligned remains 1.
- Drop pll_locked in CHECK: aligned=0 and serdes_rst=1 next cycle. Re-assert it: err_cnt cleared on RESET entry, realigns.
- rst asserted mid-TRAIN, just after a bitslip: all outputs return to their reset values the next cycle.
